// File: rtl/mips_pkg.sv
// Shared definitions for the PC sequencer: next-PC select encodings, FSM state type
// and default reset/trap addresses.
package mips_pkg;

  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_REL = 2'b01;
  localparam logic [1:0] PCSEL_MEM = 2'b10;
  localparam logic [1:0] PCSEL_REG = 2'b11;

  localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEFAULT = 32'h0000_0080;

  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } seq_state_e;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational next-PC arithmetic: fall-through address and PC-relative branch target.
module branch_target_calc (
  input  logic [31:0] pc_i,
  input  logic [15:0] imm_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] rel_target_o
);

  logic [31:0] offset;

  // Word offset: sign-extend and scale by 4; all sums wrap modulo 2^32.
  assign offset       = {{14{imm_i[15]}}, imm_i, 2'b00};
  assign pc_plus4_o   = pc_i + 32'd4;
  assign rel_target_o = pc_plus4_o + offset;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential, relative, register and memory-indirect jumps,
// with a bounded wait for the memory target and a sticky timeout flag.
//
//   state       | meaning
//   ST_RUN      | normal execution; pc updates from pcsel when instr_valid
//   ST_MEM_WAIT | waiting for mem_ack on the pointer read; fetch stalled
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter logic [31:0] TRAP_VECTOR = TRAP_VECTOR_DEFAULT,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [1:0]  pcsel,
  input  logic [15:0] imm,
  input  logic [31:0] rs_val,
  input  logic        link_req,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] pc,
  output logic        stall,
  output logic        link_we,
  output logic [31:0] link_data,
  output logic        err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
  localparam logic [31:0] RESET_PC_A    = RESET_PC & PC_ALIGN_MASK;
  localparam logic [31:0] TRAP_VECTOR_A = TRAP_VECTOR & PC_ALIGN_MASK;

  seq_state_e       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             link_we_q, link_we_d;
  logic [31:0]      link_data_q, link_data_d;

  logic [31:0] pc_plus4;
  logic [31:0] rel_target;

  branch_target_calc u_btc (
    .pc_i         (pc_q),
    .imm_i        (imm),
    .pc_plus4_o   (pc_plus4),
    .rel_target_o (rel_target)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC_A;
      mem_addr_q  <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      link_we_q   <= 1'b0;
      link_data_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mem_addr_q  <= mem_addr_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      link_we_q   <= link_we_d;
      link_data_q <= link_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mem_addr_d  = mem_addr_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    link_we_d   = 1'b0;
    link_data_d = '0;

    case (state_q)
      ST_RUN: begin
        if (instr_valid) begin
          if (link_req) begin
            link_we_d   = 1'b1;
            link_data_d = pc_plus4;
          end
          case (pcsel)
            PCSEL_SEQ: pc_d = pc_plus4;
            PCSEL_REL: pc_d = rel_target;
            PCSEL_REG: pc_d = rs_val & PC_ALIGN_MASK;
            PCSEL_MEM: begin
              mem_addr_d = rs_val;
              cnt_d      = CNT_LOAD;
              state_d    = ST_MEM_WAIT;
            end
            default:   pc_d = pc_plus4;
          endcase
        end
      end

      ST_MEM_WAIT: begin
        // An ack arriving in the expiry cycle still delivers its target.
        if (mem_ack) begin
          pc_d       = mem_rdata & PC_ALIGN_MASK;
          mem_addr_d = '0;
          cnt_d      = '0;
          state_d    = ST_RUN;
        end else if (cnt_q == CNT_LAST) begin
          pc_d       = TRAP_VECTOR_A;
          err_d      = 1'b1;
          mem_addr_d = '0;
          cnt_d      = '0;
          state_d    = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_LAST;
        end
      end

      default: state_d = ST_RUN;
    endcase
  end

  assign mem_req   = (state_q == ST_MEM_WAIT);
  assign stall     = (state_q == ST_MEM_WAIT);
  assign mem_addr  = mem_addr_q;
  assign pc        = pc_q;
  assign link_we   = link_we_q;
  assign link_data = link_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: vector table for single-cycle PC updates, plus
// hand sequences for memory-indirect wait, timeout, ack-at-expiry and reset abandonment.
module tb_pc_sequencer;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [1:0]  pcsel;
  logic [15:0] imm;
  logic [31:0] rs_val;
  logic        link_req;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] pc;
  logic        stall;
  logic        link_we;
  logic [31:0] link_data;
  logic        err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .pcsel       (pcsel),
    .imm         (imm),
    .rs_val      (rs_val),
    .link_req    (link_req),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .pc          (pc),
    .stall       (stall),
    .link_we     (link_we),
    .link_data   (link_data),
    .err         (err)
  );

  typedef struct {
    logic        iv;
    logic [1:0]  sel;
    logic [15:0] imm;
    logic [31:0] rs;
    logic        lr;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] exp_pc;
    logic        exp_lwe;
    logic [31:0] exp_ldata;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [1:0] sel, input logic [15:0] im,
                       input logic [31:0] rs, input logic lr, input logic ack,
                       input logic [31:0] rd);
    instr_valid = iv;
    pcsel       = sel;
    imm         = im;
    rs_val      = rs;
    link_req    = lr;
    mem_ack     = ack;
    mem_rdata   = rd;
  endtask

  task automatic idle();
    drive(1'b0, PCSEL_SEQ, 16'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, PCSEL_SEQ, 16'h0000, 32'h0,         1'b0, 1'b0, 32'h0,       32'h0000_0004, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, PCSEL_SEQ, 16'h0000, 32'h0,         1'b0, 1'b0, 32'h0,       32'h0000_0008, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, PCSEL_SEQ, 16'h0000, 32'h0,         1'b0, 1'b0, 32'h0,       32'h0000_000C, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, PCSEL_REG, 16'h0000, 32'h5555_5555, 1'b1, 1'b0, 32'h0,       32'h0000_000C, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, PCSEL_REG, 16'h0000, 32'h0000_0103, 1'b0, 1'b0, 32'h0,       32'h0000_0100, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, PCSEL_REL, 16'hFFFE, 32'h0,         1'b1, 1'b0, 32'h0,       32'h0000_00FC, 1'b1, 32'h0000_0104};
    vecs[6]  = '{1'b0, PCSEL_SEQ, 16'h0000, 32'h0,         1'b0, 1'b0, 32'h0,       32'h0000_00FC, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, PCSEL_REG, 16'h0000, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0,       32'hFFFF_FFFC, 1'b1, 32'h0000_0100};
    vecs[8]  = '{1'b1, PCSEL_SEQ, 16'h0000, 32'h0,         1'b0, 1'b0, 32'h0,       32'h0000_0000, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, PCSEL_REL, 16'h7FFF, 32'h0,         1'b0, 1'b0, 32'h0,       32'h0002_0000, 1'b0, 32'h0};
    vecs[10] = '{1'b1, PCSEL_REL, 16'h8000, 32'h0,         1'b1, 1'b0, 32'h0,       32'h0000_0004, 1'b1, 32'h0002_0004};
    vecs[11] = '{1'b0, PCSEL_SEQ, 16'h0000, 32'h0,         1'b0, 1'b1, 32'h0000_3330, 32'h0000_0004, 1'b0, 32'h0};

    reset = 1'b1;
    idle();
    tick();
    tick();
    chk("reset_pc", pc, 32'h0);
    chk("reset_mem_req", {31'b0, mem_req}, 32'h0);
    chk("reset_stall", {31'b0, stall}, 32'h0);
    chk("reset_link_we", {31'b0, link_we}, 32'h0);
    chk("reset_err", {31'b0, err}, 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].iv, vecs[i].sel, vecs[i].imm, vecs[i].rs, vecs[i].lr, vecs[i].ack, vecs[i].rdata);
      tick();
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("vec%0d_link_we", i), {31'b0, link_we}, {31'b0, vecs[i].exp_lwe});
      chk($sformatf("vec%0d_link_data", i), link_data, vecs[i].exp_ldata);
      chk($sformatf("vec%0d_stall", i), {31'b0, stall}, 32'h0);
    end

    // Memory-indirect jump acked in the third wait cycle.
    drive(1'b1, PCSEL_REG, 16'h0, 32'h0000_0200, 1'b0, 1'b0, 32'h0);
    tick();
    chk("mj_setup_pc", pc, 32'h0000_0200);
    drive(1'b1, PCSEL_MEM, 16'h0, 32'h0000_4000, 1'b0, 1'b0, 32'h0);
    tick();
    chk("mj_mem_req", {31'b0, mem_req}, 32'h1);
    chk("mj_mem_addr", mem_addr, 32'h0000_4000);
    chk("mj_pc_hold", pc, 32'h0000_0200);
    drive(1'b1, PCSEL_SEQ, 16'h0, 32'h0000_7777, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("mj_wait%0d_stall", i), {31'b0, stall}, 32'h1);
      chk($sformatf("mj_wait%0d_pc", i), pc, 32'h0000_0200);
      chk($sformatf("mj_wait%0d_addr", i), mem_addr, 32'h0000_4000);
      chk($sformatf("mj_wait%0d_link_we", i), {31'b0, link_we}, 32'h0);
    end
    drive(1'b0, PCSEL_SEQ, 16'h0, 32'h0, 1'b0, 1'b1, 32'h0000_1237);
    tick();
    chk("mj_ack_pc", pc, 32'h0000_1234);
    chk("mj_ack_stall", {31'b0, stall}, 32'h0);
    chk("mj_ack_mem_req", {31'b0, mem_req}, 32'h0);
    chk("mj_ack_err", {31'b0, err}, 32'h0);

    // Timeout: no ack for the full wait.
    drive(1'b1, PCSEL_MEM, 16'h0, 32'h0000_8000, 1'b0, 1'b0, 32'h0);
    tick();
    chk("to_mem_addr", mem_addr, 32'h0000_8000);
    idle();
    for (int i = 0; i < 14; i++) begin
      tick();
      chk($sformatf("to_wait%0d_stall", i), {31'b0, stall}, 32'h1);
    end
    tick();
    chk("to_pc", pc, 32'h0000_0080);
    chk("to_err", {31'b0, err}, 32'h1);
    chk("to_stall", {31'b0, stall}, 32'h0);
    drive(1'b1, PCSEL_SEQ, 16'h0, 32'h0, 1'b0, 1'b1, 32'h0000_0F00);
    tick();
    chk("to_after_pc", pc, 32'h0000_0084);
    chk("to_err_sticky", {31'b0, err}, 32'h1);

    // Ack arriving in the expiry cycle wins over the trap.
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
    chk("late_reset_err", {31'b0, err}, 32'h0);
    chk("late_reset_pc", pc, 32'h0);
    drive(1'b1, PCSEL_MEM, 16'h0, 32'h0000_9000, 1'b0, 1'b0, 32'h0);
    tick();
    idle();
    for (int i = 0; i < 14; i++) tick();
    chk("late_still_waiting", {31'b0, stall}, 32'h1);
    drive(1'b0, PCSEL_SEQ, 16'h0, 32'h0, 1'b0, 1'b1, 32'h0000_ABCE);
    tick();
    chk("late_ack_pc", pc, 32'h0000_ABCC);
    chk("late_ack_err", {31'b0, err}, 32'h0);
    chk("late_ack_stall", {31'b0, stall}, 32'h0);

    // Reset while waiting abandons the request; a stray ack afterwards is ignored.
    drive(1'b1, PCSEL_MEM, 16'h0, 32'h0000_0100, 1'b0, 1'b0, 32'h0);
    tick();
    idle();
    tick();
    chk("rst_wait_mem_req", {31'b0, mem_req}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_wait_pc", pc, 32'h0);
    chk("rst_wait_mem_req_low", {31'b0, mem_req}, 32'h0);
    chk("rst_wait_mem_addr", mem_addr, 32'h0);
    drive(1'b0, PCSEL_SEQ, 16'h0, 32'h0, 1'b0, 1'b1, 32'h0000_5550);
    tick();
    chk("rst_stray_ack_pc", pc, 32'h0);
    chk("rst_stray_ack_stall", {31'b0, stall}, 32'h0);
    idle();
    tick();
    chk("rst_final_pc", pc, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-002 SHALL have parameter TRAP_VECTOR, default 32'h0000_0080, meaning PC loaded on memory-jump timeout.
REQ-003 SHALL have parameter TIMEOUT, default 15, meaning maximum cycles waited for mem_ack.
REQ-004 SHALL have ports, one per line:
  clk  in  1  single clock; all state changes on its rising edge
  reset  in  1  synchronous, active-high reset
  instr_valid  in  1  current instruction's pcsel/imm/rs_val/link_req valid this cycle
  pcsel  in  2  next-PC select from the jump/branch controller
  imm  in  16  branch word offset, signed
  rs_val  in  32  register operand: jump target or memory pointer
  link_req  in  1  instruction writes its return address
  mem_req  out  1  memory-indirect target read request
  mem_addr  out  32  pointer address for the read
  mem_rdata  in  32  target word returned by memory
  mem_ack  in  1  mem_rdata valid; completes request
  pc  out  32  current program counter
  stall  out  1  fetch must hold; pc not advancing
  link_we  out  1  one-cycle return-address write strobe
  link_data  out  32  return address (PC+4)
  err  out  1  sticky memory-jump timeout flag

Function
REQ-005 SHALL decode pcsel as: 00 sequential, 01 PC-relative, 10 memory-addressed, 11 register.
REQ-006 SHALL implement FSM states RUN, MEM_WAIT.
REQ-007 In RUN with instr_valid=0, SHALL hold pc and all outputs low except pc.
REQ-008 In RUN with instr_valid=1 and pcsel=00, SHALL load pc <= pc+4 next cycle.
REQ-009 In RUN with instr_valid=1 and pcsel=01, SHALL load pc <= pc+4+(sign_extend(imm)<<2).
REQ-010 In RUN with instr_valid=1 and pcsel=11, SHALL load pc <= {rs_val[31:2],2'b00}.
REQ-011 In RUN with instr_valid=1 and pcsel=10, SHALL register mem_addr <= rs_val, assert mem_req and stall from next cycle, and enter MEM_WAIT; pc holds.
REQ-012 In MEM_WAIT, SHALL keep mem_req and stall high and mem_addr stable until mem_ack; SHALL ignore instr_valid.
REQ-013 On mem_ack in MEM_WAIT, SHALL load pc <= {mem_rdata[31:2],2'b00}, drop mem_req and stall next cycle, and return to RUN.
REQ-014 SHALL count MEM_WAIT cycles; if TIMEOUT cycles elapse without mem_ack, SHALL load pc <= TRAP_VECTOR, set err, and return to RUN.
REQ-015 mem_ack in the same cycle as timeout expiry SHALL win: pc <= mem_rdata target, err unchanged.
REQ-016 When instr_valid=1 and link_req=1 in RUN, SHALL pulse link_we for exactly one cycle with link_data = pc+4 of that instruction, for any pcsel.
REQ-017 All PC arithmetic SHALL be modulo 2^32; wrap past 32'hFFFF_FFFC to 0 is legal and unflagged.
REQ-018 pc[1:0] SHALL always read 2'b00.
REQ-019 mem_ack while not in MEM_WAIT SHALL be ignored.
REQ-020 err SHALL stay set until reset.

Reset
REQ-021 When reset is high at a clock edge: pc <= RESET_PC, state <= RUN, timeout counter <= 0; mem_req, stall, link_we, err, mem_addr, link_data <= 0.
REQ-022 Reset during MEM_WAIT SHALL abandon the request; mem_req low the cycle after reset; a late mem_ack SHALL be ignored.

Structure
REQ-023 Shared package mips_pkg SHALL hold the pcsel encodings (PCSEL_SEQ, PCSEL_REL, PCSEL_MEM, PCSEL_REG), the FSM state type, and RESET_PC/TRAP_VECTOR defaults.
REQ-024 One combinational sub-module branch_target_calc SHALL compute pc+4 and the PC-relative target; FSM, counter and registers stay in pc_sequencer.

Verification
REQ-025 Reset, then 3 cycles instr_valid=1, pcsel=00 -> pc 0, 4, 8, C.
REQ-026 pc=0x100, pcsel=01, imm=16'hFFFE, link_req=1 -> pc=0xFC; link_we one cycle, link_data=0x104.
REQ-027 pc=0x200, pcsel=10, rs_val=0x4000, mem_ack after 3 cycles with mem_rdata=0x1237 -> mem_addr=0x4000, stall 3+ cycles, then pc=0x1234.
REQ-028 pcsel=10, no mem_ack -> after 15 wait cycles pc=0x80, err=1; mem_ack on cycle 15 instead -> pc=target, err=0.
REQ-029 pc=0xFFFF_FFFC, pcsel=00 -> pc=0; reset asserted mid-MEM_WAIT -> pc=0, mem_req=0, later mem_ack no effect.
